// File: rtl/src_arb_pkg.sv
// Shared types and defaults for the source arbiter slice.
package src_arb_pkg;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 8;
  localparam int BURST_W = 4;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } state_t;

  // A burst limit of zero still allows one beat per grant.
  function automatic int unsigned burst_limit(input int unsigned burst_max);
    return (burst_max == 0) ? 1 : burst_max;
  endfunction

endpackage

// File: rtl/src_arbiter_rr_picker.sv
// Combinational rotate-priority encoder: first set bit of elig at or above start_ptr, wrapping.
module rr_picker #(
  parameter int NUM_SRC = src_arb_pkg::NUM_SRC,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] elig,
  input  logic [SRC_W-1:0]   start_ptr,
  output logic               found,
  output logic [SRC_W-1:0]   idx
);

  import src_arb_pkg::*;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!found && elig[(32'(start_ptr) + k) % NUM_SRC]) begin
        found = 1'b1;
        idx   = SRC_W'((32'(start_ptr) + k) % NUM_SRC);
      end
    end
  end

endmodule

// File: rtl/src_arbiter.sv
// Round-robin arbiter with per-grant burst hold, registering the winning beat onto one channel.
module src_arbiter #(
  parameter int NUM_SRC = src_arb_pkg::NUM_SRC,
  parameter int DATA_W  = src_arb_pkg::DATA_W,
  parameter int SRC_W   = $clog2(NUM_SRC),
  parameter int BURST_W = src_arb_pkg::BURST_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        req_valid,
  input  logic [NUM_SRC*DATA_W-1:0] req_data,
  output logic [NUM_SRC-1:0]        req_ready,
  input  logic [NUM_SRC-1:0]        src_en,
  input  logic [BURST_W-1:0]        burst_max,
  input  logic                      hold,
  output logic                      in_valid,
  output logic [DATA_W-1:0]         in_data,
  output logic [SRC_W-1:0]          in_src,
  output logic                      busy
);

  import src_arb_pkg::*;

  state_t             r_state, w_state_n;
  logic [SRC_W-1:0]   r_rr_ptr, w_rr_ptr_n;
  logic [SRC_W-1:0]   r_owner, w_owner_n;
  logic [BURST_W-1:0] r_beat_cnt, w_beat_cnt_n;
  logic [BURST_W-1:0] r_lim, w_lim_n;

  logic               r_in_valid;
  logic [DATA_W-1:0]  r_in_data;
  logic [SRC_W-1:0]   r_in_src;

  logic [NUM_SRC-1:0] w_elig;
  logic [SRC_W-1:0]   w_owner_inc;
  logic [SRC_W-1:0]   w_start_ptr;
  logic               w_found;
  logic [SRC_W-1:0]   w_pick_idx;
  logic               w_xfer;
  logic [SRC_W-1:0]   w_gnt_idx;
  logic [DATA_W-1:0]  w_gnt_data;
  logic [BURST_W-1:0] w_beat_inc;
  logic [BURST_W-1:0] w_new_lim;

  function automatic logic [SRC_W-1:0] inc_idx(input logic [SRC_W-1:0] i);
    return (int'(i) == NUM_SRC - 1) ? '0 : i + SRC_W'(1);
  endfunction

  assign w_elig      = req_valid & src_en;
  assign w_owner_inc = inc_idx(r_owner);
  // In BURST the picker is only consulted when the owner has dropped, so scan past it.
  assign w_start_ptr = (r_state == BURST) ? w_owner_inc : r_rr_ptr;
  assign w_beat_inc  = r_beat_cnt + BURST_W'(1);
  assign w_new_lim   = BURST_W'(burst_limit(32'(burst_max)));

  rr_picker #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_picker (
    .elig      (w_elig),
    .start_ptr (w_start_ptr),
    .found     (w_found),
    .idx       (w_pick_idx)
  );

  always_comb begin
    w_state_n    = r_state;
    w_rr_ptr_n   = r_rr_ptr;
    w_owner_n    = r_owner;
    w_beat_cnt_n = r_beat_cnt;
    w_lim_n      = r_lim;
    w_xfer       = 1'b0;
    w_gnt_idx    = r_owner;
    if (!hold) begin
      if (r_state == BURST && w_elig[r_owner]) begin
        w_xfer       = 1'b1;
        w_gnt_idx    = r_owner;
        w_beat_cnt_n = w_beat_inc;
        if (w_beat_inc == r_lim) begin
          w_state_n  = ARB;
          w_rr_ptr_n = w_owner_inc;
        end
      end else begin
        // Owner dropped mid-burst: fall back to arbitration starting after the owner.
        if (r_state == BURST) begin
          w_state_n  = ARB;
          w_rr_ptr_n = w_owner_inc;
        end
        if (w_found) begin
          w_xfer       = 1'b1;
          w_gnt_idx    = w_pick_idx;
          w_owner_n    = w_pick_idx;
          w_beat_cnt_n = BURST_W'(1);
          w_lim_n      = w_new_lim;
          if (w_new_lim == BURST_W'(1)) begin
            w_state_n  = ARB;
            w_rr_ptr_n = inc_idx(w_pick_idx);
          end else begin
            w_state_n  = BURST;
          end
        end
      end
    end
  end

  always_comb begin
    req_ready  = '0;
    w_gnt_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (w_gnt_idx == SRC_W'(i)) begin
        req_ready[i] = reset & w_xfer;
        w_gnt_data   = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ARB;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
      r_lim      <= BURST_W'(1);
    end else begin
      r_state    <= w_state_n;
      r_rr_ptr   <= w_rr_ptr_n;
      r_owner    <= w_owner_n;
      r_beat_cnt <= w_beat_cnt_n;
      r_lim      <= w_lim_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_valid <= 1'b0;
      r_in_data  <= '0;
      r_in_src   <= '0;
    end else if (w_xfer) begin
      r_in_valid <= 1'b1;
      r_in_data  <= w_gnt_data;
      r_in_src   <= w_gnt_idx;
    end else begin
      r_in_valid <= 1'b0;
    end
  end

  assign in_valid = r_in_valid;
  assign in_data  = r_in_data;
  assign in_src   = r_in_src;
  assign busy     = (r_state == BURST);

endmodule

// File: tb/tb_src_arbiter.sv
// Directed self-checking bench for src_arbiter.
module tb_src_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  src_en;
  logic [3:0]  burst_max;
  logic        hold;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [1:0]  in_src;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  src_arbiter #(
    .NUM_SRC (4),
    .DATA_W  (8),
    .SRC_W   (2),
    .BURST_W (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .src_en    (src_en),
    .burst_max (burst_max),
    .hold      (hold),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_src    (in_src),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    step();
    reset = 1'b1;
  endtask

  int seq4[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  int seq12[12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
  int seqm[7]  = '{2, 2, 2, 3, 3, 3, 2};

  initial begin
    reset     = 1'b0;
    req_valid = 4'h0;
    req_data  = {8'h30, 8'h20, 8'h10, 8'h00};
    src_en    = 4'hF;
    burst_max = 4'd1;
    hold      = 1'b0;

    // Reset state, with a request pending: ready must stay low.
    #2;
    req_valid = 4'hF;
    #1;
    chk("rst_ready", req_ready, 4'h0);
    chk("rst_valid", in_valid, 1'b0);
    chk("rst_data",  in_data, 8'h00);
    chk("rst_src",   in_src, 2'd0);
    chk("rst_busy",  busy, 1'b0);
    req_valid = 4'h0;
    step();
    reset = 1'b1;

    // Single source 2 sends 0xA5.
    req_data  = {8'h30, 8'hA5, 8'h10, 8'h00};
    req_valid = 4'b0100;
    #1;
    chk("single_ready", req_ready, 4'b0100);
    step();
    chk("single_valid", in_valid, 1'b1);
    chk("single_data",  in_data, 8'hA5);
    chk("single_src",   in_src, 2'd2);
    req_valid = 4'h0;
    step();
    chk("single_idle_valid", in_valid, 1'b0);
    chk("single_idle_data",  in_data, 8'hA5);

    // All sources, single beat.
    do_reset();
    req_data  = {8'h30, 8'h20, 8'h10, 8'h00};
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr1_ready", req_ready, 32'(4'b0001 << seq4[i]));
      step();
      chk("rr1_valid", in_valid, 1'b1);
      chk("rr1_src",   in_src, seq4[i]);
      chk("rr1_data",  in_data, 32'(seq4[i] * 16));
      chk("rr1_busy",  busy, 1'b0);
    end

    // Burst of 3 with all sources valid.
    do_reset();
    burst_max = 4'd3;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("b3_valid", in_valid, 1'b1);
      chk("b3_src",   in_src, seq12[i]);
      chk("b3_busy",  busy, ((i + 1) % 3) != 0);
    end

    // Early drop of source 0 with source 1 masked off.
    do_reset();
    src_en = 4'b1101;
    step();
    chk("drop_first_src", in_src, 2'd0);
    chk("drop_first_busy", busy, 1'b1);
    req_valid = 4'b1110;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("drop_no_src1", req_ready[1], 1'b0);
      step();
      chk("drop_valid", in_valid, 1'b1);
      chk("drop_src",   in_src, seqm[i]);
    end

    // Hold for 2 cycles mid-burst.
    do_reset();
    src_en    = 4'hF;
    burst_max = 4'd3;
    req_data  = {8'h30, 8'h20, 8'h10, 8'h0C};
    req_valid = 4'hF;
    step();
    chk("hold_b1_src", in_src, 2'd0);
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("hold_ready", req_ready, 4'h0);
      step();
      chk("hold_valid", in_valid, 1'b0);
      chk("hold_data",  in_data, 8'h0C);
      chk("hold_busy",  busy, 1'b1);
    end
    hold = 1'b0;
    #1;
    chk("hold_resume_ready", req_ready, 4'b0001);
    step();
    chk("hold_b2_src",  in_src, 2'd0);
    chk("hold_b2_busy", busy, 1'b1);
    step();
    chk("hold_b3_src",  in_src, 2'd0);
    chk("hold_b3_busy", busy, 1'b0);
    step();
    chk("hold_next_src", in_src, 2'd1);

    // Reset mid-burst of source 2.
    do_reset();
    req_data  = {8'h30, 8'h20, 8'h10, 8'h00};
    req_valid = 4'b0100;
    step();
    step();
    chk("rmid_pre_src",  in_src, 2'd2);
    chk("rmid_pre_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("rmid_valid", in_valid, 1'b0);
    chk("rmid_data",  in_data, 8'h00);
    chk("rmid_src",   in_src, 2'd0);
    chk("rmid_busy",  busy, 1'b0);
    chk("rmid_ready", req_ready, 4'h0);
    step();
    reset     = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("rmid_first_ready", req_ready, 4'b0001);
    step();
    chk("rmid_first_src", in_src, 2'd0);

    // burst_max of zero behaves as single-beat grants.
    do_reset();
    burst_max = 4'd0;
    step();
    chk("bm0_src0", in_src, 2'd0);
    chk("bm0_busy", busy, 1'b0);
    step();
    chk("bm0_src1", in_src, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
